opn_bus_writer: RTL and testbench

- Hardware bus initiator for the OPN (jt12-based `top`) CPU port.
- Accepts {register, value} write commands over a valid/ready interface.
- Drives the two-phase address/data write sequence on `din`/`addr`/`cs_n`/`wr_n`, then polls the busy flag on `dout[7]` before accepting the next command.
- Sits between a register-programming source (sequencer/ROM player/CPU shim) and the sound core; it replaces hand-timed write sequences.

---
 rtl/opn_bus_pkg.sv | 39 +++
 rtl/opn_phase_cnt.sv | 43 ++++
 rtl/opn_bus_writer.sv | 178 +++++++++++++++++
 tb/tb_opn_bus_writer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opn_bus_pkg.sv
// Shared definitions for the OPN bus writer: FSM encoding, register bases and status bits.
package opn_bus_pkg;

  // OPN register base addresses
  localparam logic [7:0] DTMUL = 8'h30;
  localparam logic [7:0] TL    = 8'h40;
  localparam logic [7:0] KSAR  = 8'h50;
  localparam logic [7:0] DR    = 8'h60;
  localparam logic [7:0] SR    = 8'h70;
  localparam logic [7:0] SLRR  = 8'h80;
  localparam logic [7:0] FBCON = 8'hB0;
  localparam logic [7:0] KEYON = 8'h28;
  localparam logic [7:0] MODE  = 8'h27;

  localparam int BUSY_BIT = 7;

  // ST_RESET keeps cmd_ready low until the first clk after reset is released
  typedef logic [3:0] opn_state_t;
  localparam opn_state_t ST_RESET   = 4'd0;
  localparam opn_state_t ST_IDLE    = 4'd1;
  localparam opn_state_t ST_A_SETUP = 4'd2;
  localparam opn_state_t ST_A_PULSE = 4'd3;
  localparam opn_state_t ST_A_HOLD  = 4'd4;
  localparam opn_state_t ST_D_SETUP = 4'd5;
  localparam opn_state_t ST_D_PULSE = 4'd6;
  localparam opn_state_t ST_D_HOLD  = 4'd7;
  localparam opn_state_t ST_SETTLE  = 4'd8;
  localparam opn_state_t ST_POLL    = 4'd9;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/opn_phase_cnt.sv
// Loadable cen-gated counter that steps toward LIMIT (down or up) and saturates there.
module opn_phase_cnt #(
  parameter int WIDTH    = 2,
  parameter bit COUNT_UP = 1'b0,
  parameter int LIMIT    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cen_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over stepping so a state can reload on the same edge it finishes
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cen_i && en_i) begin
      if (COUNT_UP) begin
        if (cnt_q < LIMIT_V) cnt_d = cnt_q + WIDTH'(1);
      end else begin
        if (cnt_q > LIMIT_V) cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/opn_bus_writer.sv
// Valid/ready command front end that drives the two-phase OPN CPU write and polls busy.
module opn_bus_writer
  import opn_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int PULSE_CYC   = 1,
  parameter int HOLD_CYC    = 1,
  parameter int USE_BUSY    = 1,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cen_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_val_i,
  input  logic [7:0] opn_dout_i,
  output logic [7:0] opn_din_o,
  output logic       opn_addr_o,
  output logic       opn_cs_n_o,
  output logic       opn_wr_n_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_err_o
);

  localparam int PH_MAX = max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, SETTLE_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PH_W-1:0] PH_SETUP  = PH_W'(SETUP_CYC);
  localparam logic [PH_W-1:0] PH_PULSE  = PH_W'(PULSE_CYC);
  localparam logic [PH_W-1:0] PH_HOLD   = PH_W'(HOLD_CYC);
  localparam logic [PH_W-1:0] PH_SETTLE = PH_W'(SETTLE_CYC);

  opn_state_t state_q, state_d;
  logic [7:0] din_q, din_d;
  logic [7:0] val_q, val_d;
  logic       done_q, done_d;
  logic       to_err_q, to_err_d;

  logic            ph_load, ph_term;
  logic [PH_W-1:0] ph_val;
  logic [PH_W-1:0] ph_cnt_unused;
  logic            to_load, to_en, to_term;
  logic [TO_W-1:0] to_cnt_unused;
  logic            unused_dout;

  assign unused_dout = ^opn_dout_i[6:0];

  opn_phase_cnt #(.WIDTH(PH_W), .COUNT_UP(1'b0), .LIMIT(1)) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cen_i      (cen_i),
    .load_i     (ph_load),
    .en_i       (1'b1),
    .load_val_i (ph_val),
    .cnt_o      (ph_cnt_unused),
    .term_o     (ph_term)
  );

  // Terminal one below TIMEOUT_CYC: the next busy sample is the one that times out
  opn_phase_cnt #(.WIDTH(TO_W), .COUNT_UP(1'b1), .LIMIT(TIMEOUT_CYC - 1)) u_timeout_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cen_i      (cen_i),
    .load_i     (to_load),
    .en_i       (to_en),
    .load_val_i ({TO_W{1'b0}}),
    .cnt_o      (to_cnt_unused),
    .term_o     (to_term)
  );

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    val_d    = val_q;
    done_d   = 1'b0;
    to_err_d = 1'b0;
    ph_load  = 1'b0;
    ph_val   = '0;
    to_load  = 1'b0;
    to_en    = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_A_SETUP;
          din_d   = cmd_reg_i;
          val_d   = cmd_val_i;
          ph_load = 1'b1;
          ph_val  = PH_SETUP;
        end
      end
      ST_A_SETUP: if (cen_i && ph_term) begin
        state_d = ST_A_PULSE;
        ph_load = 1'b1;
        ph_val  = PH_PULSE;
      end
      ST_A_PULSE: if (cen_i && ph_term) begin
        state_d = ST_A_HOLD;
        ph_load = 1'b1;
        ph_val  = PH_HOLD;
      end
      ST_A_HOLD: if (cen_i && ph_term) begin
        state_d = ST_D_SETUP;
        din_d   = val_q;
        ph_load = 1'b1;
        ph_val  = PH_SETUP;
      end
      ST_D_SETUP: if (cen_i && ph_term) begin
        state_d = ST_D_PULSE;
        ph_load = 1'b1;
        ph_val  = PH_PULSE;
      end
      ST_D_PULSE: if (cen_i && ph_term) begin
        state_d = ST_D_HOLD;
        ph_load = 1'b1;
        ph_val  = PH_HOLD;
      end
      ST_D_HOLD: if (cen_i && ph_term) begin
        if (USE_BUSY != 0) begin
          state_d = ST_SETTLE;
          ph_load = 1'b1;
          ph_val  = PH_SETTLE;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_SETTLE: if (cen_i && ph_term) begin
        state_d = ST_POLL;
        to_load = 1'b1;
      end
      ST_POLL: if (cen_i) begin
        if (!opn_dout_i[BUSY_BIT]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (to_term) begin
          state_d  = ST_IDLE;
          to_err_d = 1'b1;
        end else begin
          to_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RESET;
      din_q    <= 8'h00;
      val_q    <= 8'h00;
      done_q   <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      val_q    <= val_d;
      done_q   <= done_d;
      to_err_q <= to_err_d;
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_RESET);
  assign opn_cs_n_o    = !(state_q inside {ST_A_SETUP, ST_A_PULSE, ST_A_HOLD,
                                           ST_D_SETUP, ST_D_PULSE, ST_D_HOLD});
  assign opn_wr_n_o    = !(state_q inside {ST_A_PULSE, ST_D_PULSE});
  assign opn_addr_o    = state_q inside {ST_D_SETUP, ST_D_PULSE, ST_D_HOLD};
  assign opn_din_o     = din_q;
  assign done_o        = done_q;
  assign timeout_err_o = to_err_q;

endmodule

// File: tb/tb_opn_bus_writer.sv
// Randomised bench for opn_bus_writer; expected bus levels come from a phase-length model.
module tb_opn_bus_writer;
  import opn_bus_pkg::*;

  localparam int SETUP = 1, PULSE = 1, HOLD = 1, SETTLE = 2, TMO = 16;
  localparam int PHASE_END  = 2 * (SETUP + PULSE + HOLD);
  localparam int POLL_START = PHASE_END + SETTLE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic [7:0] cmdReg = 8'h00;
  logic [7:0] cmdVal = 8'h00;
  logic [7:0] opnDout = 8'h00;
  logic [7:0] din;
  logic       addr, csN, wrN, busyO, done, terr;

  int total = 0;
  int bad = 0;
  int doneCnt = 0;

  always #5 clk = ~clk;

  // done is a one-clk pulse, so every pulse is seen by exactly one falling edge
  always @(negedge clk) if (done === 1'b1) doneCnt <= doneCnt + 1;

  opn_bus_writer #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
    .USE_BUSY(1), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cen_i(cen),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
    .cmd_reg_i(cmdReg), .cmd_val_i(cmdVal), .opn_dout_i(opnDout),
    .opn_din_o(din), .opn_addr_o(addr), .opn_cs_n_o(csN), .opn_wr_n_o(wrN),
    .busy_o(busyO), .done_o(done), .timeout_err_o(terr)
  );

  // Bus levels {cs_n, wr_n, addr, din} after n cen-edges since the accept edge
  function automatic logic [10:0] expBus(int n, logic [7:0] r, logic [7:0] v);
    int dur[6];
    int acc;
    int p;
    dur = '{SETUP, PULSE, HOLD, SETUP, PULSE, HOLD};
    acc = 0;
    p = 6;
    for (int i = 0; i < 6; i++) begin
      acc += dur[i];
      if (p == 6 && n < acc) p = i;
    end
    if (p == 6) return {1'b1, 1'b1, 1'b0, v};
    return {1'b0, (p == 1 || p == 4) ? 1'b0 : 1'b1, (p >= 3) ? 1'b1 : 1'b0, (p >= 3) ? v : r};
  endfunction

  task automatic run_cmd(input logic [7:0] r, input logic [7:0] v, input int busyN,
                         input int cenMode, input bit holdValid,
                         output int waitCyc, output int latency,
                         output int pollEdges, output int wrLow);
    int n, samples, outcome, tick;
    bit sampleBusy, cenNow;
    logic [10:0] expB;
    logic [3:0]  expS;
    cmdReg = r;
    cmdVal = v;
    cmdValid = 1'b1;
    waitCyc = 0;
    latency = 0;
    pollEdges = 0;
    wrLow = 0;
    while (cmdReady !== 1'b1 && waitCyc < 64) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    total++;
    if (cmdReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL accept: cmd_ready=%b want 1", cmdReady);
      cmdValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmdValid = holdValid;
    cmdReg = 8'($urandom);
    cmdVal = 8'($urandom);
    n = 0;
    samples = 0;
    outcome = 0;
    tick = 0;
    for (int c = 0; c < 2000; c++) begin
      expB = expBus(n, r, v);
      total++;
      if ({csN, wrN, addr, din} !== expB) begin
        bad++;
        $display("[TB] FAIL bus n=%0d: got %h want %h", n, {csN, wrN, addr, din}, expB);
      end
      total++;
      if ({busyO, cmdReady, done, terr} !== 4'b1000) begin
        bad++;
        $display("[TB] FAIL status n=%0d: got %b want 1000", n, {busyO, cmdReady, done, terr});
      end
      if (wrN === 1'b0) wrLow++;
      case (cenMode)
        0:       cenNow = 1'b1;
        1:       cenNow = (tick % 4 == 3);
        default: cenNow = 1'($urandom_range(0, 1));
      endcase
      tick++;
      sampleBusy = (samples < busyN);
      cen = cenNow;
      opnDout = {sampleBusy, 7'($urandom)};
      @(posedge clk); #1;
      latency++;
      if (cenNow) begin
        if (n >= POLL_START) begin
          samples++;
          if (!sampleBusy) outcome = 1;
          else if (samples == TMO) outcome = 2;
        end
        n++;
      end
      if (outcome != 0) break;
    end
    pollEdges = samples;
    total++;
    if (outcome == 0) begin
      bad++;
      $display("[TB] FAIL completion: no end after %0d clk, want done or timeout", latency);
    end else begin
      expS = {1'b0, 1'b1, outcome == 1, outcome == 2};
      if ({busyO, cmdReady, done, terr} !== expS) begin
        bad++;
        $display("[TB] FAIL end_status: got %b want %b", {busyO, cmdReady, done, terr}, expS);
      end
      total++;
      if ({csN, wrN, addr, din} !== {3'b110, v}) begin
        bad++;
        $display("[TB] FAIL end_bus: got %h want %h", {csN, wrN, addr, din}, {3'b110, v});
      end
    end
    if (!holdValid) begin
      cen = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({busyO, cmdReady, done, terr} !== 4'b0100) begin
        bad++;
        $display("[TB] FAIL pulse_end: got %b want 0100", {busyO, cmdReady, done, terr});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmdValid = 1'b1;
    cmdReg = 8'hAA;
    cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({csN, wrN, addr, din} !== {3'b110, 8'h00}) begin
        bad++;
        $display("[TB] FAIL reset_bus: got %h want %h", {csN, wrN, addr, din}, {3'b110, 8'h00});
      end
      total++;
      if ({busyO, cmdReady, done, terr} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_status: got %b want 0000", {busyO, cmdReady, done, terr});
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    total++;
    if ({busyO, cmdReady, done, terr} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b want 0100", {busyO, cmdReady, done, terr});
    end
  endtask

  task automatic test_basic();
    int w, lat, pe, wl;
    run_cmd(MODE, 8'h3B, 0, 0, 1'b0, w, lat, pe, wl);
    total++;
    if (lat != 9) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 9", lat); end
    total++;
    if (wl != 2) begin bad++; $display("[TB] FAIL basic_wr_low: got %0d want 2", wl); end
  endtask

  task automatic test_back_to_back();
    int w, lat, pe, wl, base;
    base = doneCnt;
    run_cmd(8'h07, 8'h38, 0, 0, 1'b1, w, lat, pe, wl);
    run_cmd(8'h01, 8'h01, 0, 0, 1'b0, w, lat, pe, wl);
    total++;
    if (w != 0) begin bad++; $display("[TB] FAIL b2b_gap: got %0d want 0", w); end
    total++;
    if (doneCnt - base != 2) begin
      bad++;
      $display("[TB] FAIL b2b_done_count: got %0d want 2", doneCnt - base);
    end
  endtask

  task automatic test_busy_stall();
    int w, lat, pe, wl;
    run_cmd(SR, 8'($urandom), 10, 0, 1'b0, w, lat, pe, wl);
    total++;
    if (pe != 11) begin bad++; $display("[TB] FAIL stall_poll: got %0d want 11", pe); end
  endtask

  task automatic test_timeout();
    int w, lat, pe, wl, base;
    base = doneCnt;
    run_cmd(KEYON, 8'hF0, 1000, 0, 1'b0, w, lat, pe, wl);
    total++;
    if (pe != TMO) begin bad++; $display("[TB] FAIL timeout_poll: got %0d want %0d", pe, TMO); end
    total++;
    if (doneCnt != base) begin
      bad++;
      $display("[TB] FAIL timeout_done: got %0d want %0d", doneCnt, base);
    end
  endtask

  task automatic test_cen_stretch();
    int w, lat, pe, wl;
    run_cmd(FBCON, 8'h28, 0, 1, 1'b0, w, lat, pe, wl);
    total++;
    if (wl != 8) begin bad++; $display("[TB] FAIL cen_wr_low: got %0d want 8", wl); end
  endtask

  task automatic test_random();
    logic [7:0] regs[9];
    int w, lat, pe, wl, busyN, want;
    regs = '{DTMUL, TL, KSAR, DR, SR, SLRR, FBCON, KEYON, MODE};
    for (int i = 0; i < 6; i++) begin
      busyN = $urandom_range(0, 20);
      run_cmd(regs[$urandom_range(0, 8)], 8'($urandom), busyN, 2, 1'b0, w, lat, pe, wl);
      want = (busyN >= TMO) ? TMO : busyN + 1;
      total++;
      if (pe != want) begin bad++; $display("[TB] FAIL rand_poll[%0d]: got %0d want %0d", i, pe, want); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int base;
    v = 8'($urandom);
    cmdReg = KSAR;
    cmdVal = v;
    cmdValid = 1'b1;
    cen = 1'b1;
    total++;
    if (cmdReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready: got %b want 1", cmdReady); end
    @(posedge clk); #1;
    cmdValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({csN, wrN, addr, din} !== expBus(4, KSAR, v)) begin
      bad++;
      $display("[TB] FAIL mid_d_pulse: got %h want %h", {csN, wrN, addr, din}, expBus(4, KSAR, v));
    end
    base = doneCnt;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({csN, wrN, addr, din} !== {3'b110, 8'h00}) begin
      bad++;
      $display("[TB] FAIL mid_reset_bus: got %h want %h", {csN, wrN, addr, din}, {3'b110, 8'h00});
    end
    @(posedge clk); #1;
    total++;
    if ({busyO, cmdReady, done, terr} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_reset_status: got %b want 0000", {busyO, cmdReady, done, terr});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busyO, cmdReady, done, terr} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL mid_release: got %b want 0100", {busyO, cmdReady, done, terr});
    end
    @(posedge clk); #1;
    total++;
    if (doneCnt != base) begin
      bad++;
      $display("[TB] FAIL mid_no_done: got %0d want %0d", doneCnt, base);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_stall();
    test_timeout();
    test_cen_stretch();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
